// File: rtl/alu_branch_pipe.sv
// Two-stage ALU/branch-compare pipeline with valid/ready handshakes, flush and a sticky illegal-op flag.
// Optional build macro ALU_BRANCH_PERF_CNT_EN adds a saturating taken-branch counter (taken_cnt).
module alu_branch_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sign,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ofl,
  output logic             out_zero,
  output logic             out_branch,
  output logic             out_err,
  output logic             err_sticky,
  input  logic             err_clr
`ifdef ALU_BRANCH_PERF_CNT_EN
  ,
  output logic [15:0]      taken_cnt
`endif
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_BEQ = 3'b010,
    OP_BNE = 3'b011,
    OP_BLT = 3'b100,
    OP_BGE = 3'b101,
    OP_JMP = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  // Stage 1: decoded operation and operands
  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_sign_q, s1_sign_d;

  // Stage 2: registered result and flags (held at zero while invalid)
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_ofl_q, s2_ofl_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_branch_q, s2_branch_d;
  logic             s2_err_q, s2_err_d;

  logic             err_sticky_q, err_sticky_d;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;

  // Execute-stage combinational results computed from S1
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] exe_result;
  logic             exe_ofl;
  logic             exe_branch;
  logic             exe_err;
  logic             lt;
  logic             add_sovf;
  logic             sub_sovf;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s2_adv || !s1_valid_q;
  assign in_ready = s1_adv && !in_flush && !rst;
  assign accept   = in_valid && in_ready;

  assign add_full = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign sub_full = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{WIDTH{1'b0}}, 1'b1};

  // Signed overflow: result sign differs from A when operand signs make overflow possible
  assign add_sovf = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                    (add_full[WIDTH-1] != s1_a_q[WIDTH-1]);
  assign sub_sovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                    (sub_full[WIDTH-1] != s1_a_q[WIDTH-1]);

  assign lt = s1_sign_q ? ($signed(s1_a_q) < $signed(s1_b_q)) : (s1_a_q < s1_b_q);

  always_comb begin
    exe_result = '0;
    exe_ofl    = 1'b0;
    exe_branch = 1'b0;
    exe_err    = 1'b0;
    unique case (s1_op_q)
      OP_ADD: begin
        exe_result = add_full[WIDTH-1:0];
        exe_ofl    = s1_sign_q ? add_sovf : add_full[WIDTH];
      end
      OP_SUB: begin
        exe_result = sub_full[WIDTH-1:0];
        // Unsigned: missing carry-out of A+~B+1 means A<B (borrow)
        exe_ofl    = s1_sign_q ? sub_sovf : !sub_full[WIDTH];
      end
      OP_BEQ: exe_branch = (s1_a_q == s1_b_q);
      OP_BNE: exe_branch = (s1_a_q != s1_b_q);
      OP_BLT: exe_branch = lt;
      OP_BGE: exe_branch = !lt;
      OP_JMP: begin
        exe_result = add_full[WIDTH-1:0];
        exe_branch = 1'b1;
      end
      OP_ILL: exe_err = 1'b1;
      default: exe_err = 1'b1;
    endcase
    if (s1_op_q inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE}) begin
      exe_result = {{(WIDTH-1){1'b0}}, exe_branch};
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sign_d  = s1_sign_q;
    if (in_flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_op_d   = op_e'(in_op);
        s1_a_d    = in_a;
        s1_b_d    = in_b;
        s1_sign_d = in_sign;
      end
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_ofl_d    = s2_ofl_q;
    s2_zero_d   = s2_zero_q;
    s2_branch_d = s2_branch_q;
    s2_err_d    = s2_err_q;
    if (in_flush || (s2_adv && !s1_valid_q)) begin
      s2_valid_d  = 1'b0;
      s2_result_d = '0;
      s2_ofl_d    = 1'b0;
      s2_zero_d   = 1'b0;
      s2_branch_d = 1'b0;
      s2_err_d    = 1'b0;
    end else if (s2_adv) begin
      s2_valid_d  = 1'b1;
      s2_result_d = exe_result;
      s2_ofl_d    = exe_ofl;
      s2_zero_d   = (exe_result == '0);
      s2_branch_d = exe_branch;
      s2_err_d    = exe_err;
    end
  end

  // Setting beats clearing when both happen in the same cycle
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (err_clr) begin
      err_sticky_d = 1'b0;
    end
    if (!in_flush && s2_adv && s1_valid_q && exe_err) begin
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_ADD;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_sign_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_ofl_q     <= 1'b0;
      s2_zero_q    <= 1'b0;
      s2_branch_q  <= 1'b0;
      s2_err_q     <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_sign_q    <= s1_sign_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_ofl_q     <= s2_ofl_d;
      s2_zero_q    <= s2_zero_d;
      s2_branch_q  <= s2_branch_d;
      s2_err_q     <= s2_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_ofl    = s2_ofl_q;
  assign out_zero   = s2_zero_q;
  assign out_branch = s2_branch_q;
  assign out_err    = s2_err_q;
  assign err_sticky = err_sticky_q;

`ifdef ALU_BRANCH_PERF_CNT_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;

  // Counts on the handshake itself, so a stalled result is counted exactly once
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (s2_valid_q && out_ready && s2_branch_q && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_alu_branch_pipe.sv
// Directed, table-driven bench for alu_branch_pipe (WIDTH=16) plus hand-written stall/flush/reset sequences.
module tb_alu_branch_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sign;
  logic         in_flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_ofl;
  logic         out_zero;
  logic         out_branch;
  logic         out_err;
  logic         err_sticky;
  logic         err_clr;
`ifdef ALU_BRANCH_PERF_CNT_EN
  logic [15:0]  taken_cnt;
`endif

  alu_branch_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sign    (in_sign),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ofl    (out_ofl),
    .out_zero   (out_zero),
    .out_branch (out_branch),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
`ifdef ALU_BRANCH_PERF_CNT_EN
    ,
    .taken_cnt  (taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sign;
    logic [W-1:0] res;
    logic         ofl;
    logic         zero;
    logic         br;
    logic         err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  vec_t vecs [15];

  logic [2:0]   s_op  [8];
  logic [W-1:0] s_a   [8];
  logic [W-1:0] s_b   [8];
  logic [W-1:0] s_res [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    int lat;
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = v.op;
    in_a     = v.a;
    in_b     = v.b;
    in_sign  = v.sign;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'd2);
    chk($sformatf("vec%0d_outputs", idx),
        64'({out_result, out_ofl, out_zero, out_branch, out_err}),
        64'({v.res, v.ofl, v.zero, v.br, v.err}));
    $display("vec%0d op=%0d a=%h b=%h sign=%0b -> res=%h ofl=%0b zero=%0b br=%0b err=%0b",
             idx, v.op, v.a, v.b, v.sign, out_result, out_ofl, out_zero, out_branch, out_err);
  endtask

  // Issue n ops from s_* back to back, holding out_ready low for cycles st_lo..st_hi
  task automatic stream(input string tag, input int n, input int st_lo, input int st_hi);
    int   sent;
    int   got;
    logic stall_prev;
    logic [W+3:0] prev;
    logic saw_bp;
    logic acc;
    int   extra;
    sent = 0;
    got = 0;
    stall_prev = 1'b0;
    prev = '0;
    saw_bp = 1'b0;
    for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= st_lo && cyc <= st_hi);
      in_valid  = (sent < n);
      if (sent < n) begin
        in_op   = s_op[sent];
        in_a    = s_a[sent];
        in_b    = s_b[sent];
        in_sign = 1'b0;
      end
      #1;
      if (stall_prev) begin
        chk($sformatf("%s_hold_c%0d", tag, cyc),
            64'({out_valid, out_result, out_ofl, out_zero, out_branch, out_err}),
            64'({1'b1, prev}));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("%s_res%0d", tag, got), 64'(out_result), 64'(s_res[got]));
        $display("%s result %0d = %h", tag, got, out_result);
        got++;
      end
      if (sent < n && !in_ready) saw_bp = 1'b1;
      acc        = in_valid && in_ready;
      stall_prev = out_valid && !out_ready;
      prev       = {out_result, out_ofl, out_zero, out_branch, out_err};
      @(posedge clk);
      if (acc) sent++;
    end
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    chk($sformatf("%s_delivered", tag), 64'(got), 64'(n));
    chk($sformatf("%s_backpressure", tag), 64'(saw_bp), 64'd1);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk($sformatf("%s_no_extra", tag), 64'(extra), 64'd0);
  endtask

  initial begin
    int emitted;
    vecs[0]  = '{3'd0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'd1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd4, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'd4, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'd2, 16'h1234, 16'h1234, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'd3, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd7, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{3'd5, 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'd5, 16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3'd6, 16'h1000, 16'h0234, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'd1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'd1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_sign = 1'b0;
    in_flush = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        64'({out_valid, out_result, out_ofl, out_zero, out_branch, out_err, err_sticky, in_ready}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(i);

    @(negedge clk);
    chk("sticky_after_legal_ops", 64'(err_sticky), 64'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("sticky_cleared", 64'(err_sticky), 64'd0);

    // Clear requested in the very cycle an illegal op enters S2
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd7; in_a = 16'h0001; in_b = 16'h0002;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("sticky_set_wins", 64'({err_sticky, out_valid, out_err}), 64'b111);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;

    s_op[0] = 3'd0; s_a[0] = 16'd1; s_b[0] = 16'd1; s_res[0] = 16'd2;
    s_op[1] = 3'd0; s_a[1] = 16'd2; s_b[1] = 16'd2; s_res[1] = 16'd4;
    s_op[2] = 3'd0; s_a[2] = 16'd3; s_b[2] = 16'd3; s_res[2] = 16'd6;
    s_op[3] = 3'd0; s_a[3] = 16'd4; s_b[3] = 16'd4; s_res[3] = 16'd8;
    stream("bp4", 4, 3, 5);

    // Flush with two ops in flight and consumer stalled
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_a = 16'd10; in_b = 16'd1;
    @(posedge clk);
    #1 in_a = 16'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("flush_pre_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1; in_a = 16'd30; in_flush = 1'b1;
    #1 chk("flush_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 in_flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_kill", 64'({out_valid, out_result, out_err}), 64'd0);
    out_ready = 1'b1;
    emitted = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) emitted++;
    end
    chk("flush_no_emit", 64'(emitted), 64'd0);

    // Reset with an illegal op and an ADD in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd7; in_a = 16'd1; in_b = 16'd1;
    @(posedge clk);
    #1 in_op = 3'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_sticky", 64'({err_sticky, out_err}), 64'b11);
    rst = 1'b1; in_flush = 1'b1; err_clr = 1'b1;
    @(posedge clk);
    #1 in_flush = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    chk("rst_all_zero",
        64'({out_valid, out_result, out_ofl, out_zero, out_branch, out_err, err_sticky, in_ready}), 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    emitted = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) emitted++;
    end
    chk("rst_no_emit", 64'(emitted), 64'd0);

`ifdef ALU_BRANCH_PERF_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("cnt_reset", 64'(taken_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      s_op[i] = 3'd2; s_a[i] = 16'd5; s_b[i] = 16'd5; s_res[i] = 16'd1;
    end
    s_op[3] = 3'd6; s_a[3] = 16'h0010; s_b[3] = 16'h0020; s_res[3] = 16'h0030;
    s_op[4] = 3'd3; s_a[4] = 16'd7; s_b[4] = 16'd7; s_res[4] = 16'd0;
    s_op[5] = 3'd3; s_a[5] = 16'd7; s_b[5] = 16'd7; s_res[5] = 16'd0;
    stream("cnt6", 6, 2, 4);
    chk("taken_cnt", 64'(taken_cnt), 64'd4);
    $display("taken_cnt = %0d", taken_cnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_branch_pipe.md
ALU_BRANCH_PIPE -- requirements
Module: alu_branch_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width, legal range 4..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation presented.
REQ-005 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-006 SHALL have port in_op  input  3  000 ADD, 001 SUB (A-B), 010 BEQ, 011 BNE, 100 BLT, 101 BGE, 110 JMP, 111 illegal.
REQ-007 SHALL have ports in_a, in_b  input  WIDTH  operands; in_sign  input  1  1 = signed compare/overflow.
REQ-008 SHALL have port in_flush  input  1  kill all in-flight operations.
REQ-009 SHALL have port out_valid  output  1  result available; out_ready  input  1  consumer accepts.
REQ-010 SHALL have ports out_result  output  WIDTH, out_ofl, out_zero, out_branch, out_err  output  1 each.
REQ-011 SHALL have ports err_sticky  output  1  latched illegal-op flag; err_clr  input  1  clears it.

Function
REQ-012 SHALL be a two-stage pipeline: S1 registers decoded op and operands, S2 registers result and flags; accept-to-out_valid latency exactly 2 cycles with out_ready held high.
REQ-013 SHALL advance S2 when !S2.valid || out_ready; S1 advances when S2 advances or !S1.valid; in_ready = S1 advance condition && !in_flush.
REQ-014 SHALL hold out_* stable while out_valid && !out_ready; sustain one op per cycle with out_ready high.
REQ-015 ADD: result = A+B mod 2^WIDTH; SUB and JMP use A+~B+1 for SUB, A+B for JMP.
REQ-016 out_ofl for ADD/SUB: in_sign=1 -> two's-complement overflow; in_sign=0 -> carry-out (ADD) or borrow, i.e. A<B unsigned (SUB); 0 for all other ops.
REQ-017 BEQ/BNE/BLT/BGE: out_branch = (A==B), (A!=B), (A<B), (A>=B); BLT/BGE compare signed if in_sign else unsigned; out_result = zero-extended out_branch.
REQ-018 JMP: out_branch = 1; ADD/SUB: out_branch = 0.
REQ-019 out_zero = (out_result == 0) for every op.
REQ-020 Illegal op (111): out_err = 1, out_result = 0, out_branch = 0, out_ofl = 0; still flows through pipeline and occupies a slot.
REQ-021 err_sticky SHALL set the cycle an illegal op is registered into S2 and remain set until err_clr; simultaneous set and clear -> set wins.
REQ-022 in_flush SHALL clear S1.valid and S2.valid next cycle; input presented same cycle is not accepted (in_ready low); err_sticky unaffected.
REQ-023 Output flags SHALL be don't-care-free: all out_* driven 0 whenever out_valid = 0.

Reset
REQ-024 On rst: S1.valid = S2.valid = 0, out_valid = 0, out_result = 0, out_ofl = out_zero = out_branch = out_err = 0, err_sticky = 0, taken counter = 0.
REQ-025 rst mid-operation SHALL discard all in-flight ops; in_ready = 0 during rst; rst dominates in_flush and err_clr.

Configuration
REQ-026 Macro ALU_BRANCH_PERF_CNT_EN defined: adds output taken_cnt (16 bits), incremented once per result handshake (out_valid && out_ready) with out_branch = 1, saturating at 16'hFFFF, cleared by rst only.
REQ-027 Macro undefined: no taken_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-028 WIDTH=16, ADD 16'h7FFF+16'h0001, sign=1 -> 2 cycles later out_result=16'h8000, out_ofl=1, out_zero=0; sign=0 -> out_ofl=0.
REQ-029 SUB 16'h0003-16'h0005, sign=0 -> out_result=16'hFFFE, out_ofl=1; BLT A=16'hFFFF B=16'h0001: sign=1 -> out_branch=1, sign=0 -> out_branch=0.
REQ-030 Back-to-back 4 ops, out_ready low cycles 3-5 -> in_ready drops once both stages full, out_* held, all 4 results delivered in order, none lost/duplicated.
REQ-031 Op 111 -> out_err=1, err_sticky=1 persists over following legal ops; err_clr with another illegal op in S2 same cycle -> err_sticky stays 1.
REQ-032 Two ops in flight, in_flush pulse -> out_valid=0 next cycle, neither result emitted; rst asserted with ops in flight -> all outputs 0 next cycle.
REQ-033 With ALU_BRANCH_PERF_CNT_EN: 3 BEQ equal + 1 JMP + 2 BNE equal, all accepted -> taken_cnt=4; output stalled results counted once only.
